mipi_cam_init_seq: RTL and testbench
====================================

MIPI_CAM_INIT_SEQ -- requirements
Module: mipi_cam_init_seq

Interface
REQ-001 SHALL have parameter PWDN_CYC, default 50000; cycles O_Cam_Pwdn held high after start (1 ms @ 50 MHz).
REQ-002 SHALL have parameter RST_CYC, default 1000000; cycles O_Cam_Rst_n held low after power-up (20 ms).
REQ-003 SHALL have parameter BOOT_CYC, default 1000000; cycles waited after reset release before config starts.
REQ-004 SHALL have parameter CFG_TIMEOUT_CYC, default 50000000; max cycles in CFG awaiting done (1 s).
REQ-005 SHALL have parameter MAX_RETRY, default 3; configuration attempts allowed before FAULT.
REQ-006 SHALL have port I_Top_Sys_Clk  in  1  system clock, 50 MHz.
REQ-007 SHALL have port I_Top_Rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port I_Start  in  1  single-cycle pulse; starts or restarts the sequence.
REQ-009 SHALL have port I_Cfg_Done  in  1  config-engine done; asynchronous to I_Top_Sys_Clk.
REQ-010 SHALL have port O_Cfg_Sclk  out  1  config-engine clock, I_Top_Sys_Clk/64 (free-running 6-bit divider MSB).
REQ-011 SHALL have ports O_Cam_Pwdn (active-high), O_Cam_Rst_n, O_Cfg_Rst_n, O_Phy_Rst_n  out  1  each.
REQ-012 SHALL have ports O_Ready, O_Fault  out  1; O_State  out  3; O_Retry_Cnt  out  2.

Function
REQ-013 SHALL implement states IDLE(0), PWR_DN(1), RST_HOLD(2), BOOT_WAIT(3), CFG(4), PHY_EN(5), READY(6), FAULT(7); O_State = encoding, registered.
REQ-014 IDLE: O_Cam_Pwdn=1, all resets asserted; I_Start -> PWR_DN, O_Retry_Cnt cleared.
REQ-015 PWR_DN: O_Cam_Pwdn=1, O_Cam_Rst_n=0 for exactly PWDN_CYC cycles -> RST_HOLD.
REQ-016 RST_HOLD: O_Cam_Pwdn=0, O_Cam_Rst_n=0 for exactly RST_CYC cycles -> BOOT_WAIT.
REQ-017 BOOT_WAIT: O_Cam_Rst_n=1 for exactly BOOT_CYC cycles -> CFG.
REQ-018 CFG: O_Cfg_Rst_n=1; synchronized I_Cfg_Done high -> PHY_EN; CFG_TIMEOUT_CYC cycles elapsed without done -> timeout handling (REQ-025).
REQ-019 PHY_EN: O_Phy_Rst_n=1; after 16 cycles -> READY.
REQ-020 READY: O_Ready=1; O_Cfg_Rst_n, O_Phy_Rst_n remain 1; synchronized I_Cfg_Done falling is ignored.
REQ-021 FAULT: O_Fault=1, O_Cam_Pwdn=1, all resets asserted.
REQ-022 I_Start in READY or FAULT SHALL restart at PWR_DN with O_Retry_Cnt cleared; I_Start in states 1-5 SHALL be ignored.
REQ-023 I_Cfg_Done SHALL pass a 2-flop synchronizer; done seen outside CFG SHALL have no effect.
REQ-024 One shared down-counter, loaded on each state entry, width $clog2 of max of all cycle parameters; a state with count N lasts exactly N cycles.
REQ-025 Simultaneous synchronized done and timeout in CFG: done SHALL win.

Reset
REQ-026 On I_Top_Rst_n low: state IDLE, counter and divider 0, O_Cam_Pwdn=1, O_Cam_Rst_n=0, O_Cfg_Rst_n=0, O_Phy_Rst_n=0, O_Ready=0, O_Fault=0, O_Retry_Cnt=0, O_Cfg_Sclk=0.
REQ-027 Reset mid-sequence SHALL abort immediately to IDLE; no automatic start after reset release.

Configuration
REQ-028 With MIPI_SEQ_RETRY_EN defined: CFG timeout increments O_Retry_Cnt and re-enters PWR_DN while O_Retry_Cnt+1 < MAX_RETRY, else FAULT.
REQ-029 Without MIPI_SEQ_RETRY_EN: CFG timeout goes directly to FAULT; O_Retry_Cnt constant 0.

Structure
REQ-030 State encoding and divider width SHALL live in shared package mipi_seq_pkg.
REQ-031 Single sub-module SHALL be cdc_sync2 (2-flop synchronizer); all else in one module.

Verification (PWDN_CYC=4, RST_CYC=8, BOOT_CYC=6, CFG_TIMEOUT_CYC=20, MAX_RETRY=2)
REQ-032 Start pulse, done raised 10 cycles into CFG -> O_Cam_Pwdn falls 4 cycles after PWR_DN entry, O_Cam_Rst_n rises 8 later, O_Cfg_Rst_n 6 later, O_Ready 16 cycles after PHY_EN entry.
REQ-033 Retry enabled, done never raised -> two CFG timeouts, O_Retry_Cnt=1 after the first, FAULT after the second, O_Fault=1.
REQ-034 Retry disabled, done never raised -> FAULT after first timeout, O_Retry_Cnt=0.
REQ-035 Reset asserted in RST_HOLD -> all outputs at REQ-026 values the same cycle; stays IDLE after release until I_Start.
REQ-036 Start pulse in BOOT_WAIT ignored; start pulse in READY restarts at PWR_DN; done held high from IDLE -> CFG exits on 3rd cycle (sync latency).

Source files
------------

// File: rtl/mipi_seq_pkg.sv
// Shared definitions for the MIPI camera power-up / init sequencer:
// state encoding, divider width and sequencer constants.
package mipi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWR_DN    = 3'd1,
        ST_RST_HOLD  = 3'd2,
        ST_BOOT_WAIT = 3'd3,
        ST_CFG       = 3'd4,
        ST_PHY_EN    = 3'd5,
        ST_READY     = 3'd6,
        ST_FAULT     = 3'd7
    } seq_state_e;

    // Config-engine clock is the MSB of a free-running divider (sys/64).
    localparam int unsigned DIV_W = 6;

    // Cycles the PHY reset is released before the sequencer reports ready.
    localparam int unsigned PHY_EN_CYC = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer with a synchronous clear so that stale input
// history is flushed whenever the consumer is not listening.
module cdc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next value of both stages; clear forces the chain empty.
    always_comb begin
        meta_d = clr ? 1'b0 : d;
        sync_d = clr ? 1'b0 : meta_q;
    end

    // Synchronizer stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mipi_cam_init_seq.sv
// MIPI camera power-up / configuration sequencer.
// Walks the sensor through power-down, reset hold, boot wait, register
// configuration and PHY enable, with a timeout on configuration.
// Optional feature: define MIPI_SEQ_RETRY_EN to retry configuration on
// timeout (up to MAX_RETRY attempts) instead of faulting immediately.
module mipi_cam_init_seq
    import mipi_seq_pkg::*;
#(
    parameter int unsigned PWDN_CYC        = 50000,
    parameter int unsigned RST_CYC         = 1000000,
    parameter int unsigned BOOT_CYC        = 1000000,
    parameter int unsigned CFG_TIMEOUT_CYC = 50000000,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic       I_Top_Sys_Clk,
    input  logic       I_Top_Rst_n,
    input  logic       I_Start,
    input  logic       I_Cfg_Done,
    output logic       O_Cfg_Sclk,
    output logic       O_Cam_Pwdn,
    output logic       O_Cam_Rst_n,
    output logic       O_Cfg_Rst_n,
    output logic       O_Phy_Rst_n,
    output logic       O_Ready,
    output logic       O_Fault,
    output logic [2:0] O_State,
    output logic [1:0] O_Retry_Cnt
);

`ifdef MIPI_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int unsigned CNT_MAX = max_u(max_u(PWDN_CYC, RST_CYC),
                                            max_u(max_u(BOOT_CYC, CFG_TIMEOUT_CYC), PHY_EN_CYC));
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Counter is loaded with N-1 on entry and the state exits when it reads 0,
    // giving exactly N cycles of residency.
    localparam logic [CNT_W-1:0] LD_PWDN = CNT_W'(PWDN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RST  = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] LD_BOOT = CNT_W'(BOOT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CFG  = CNT_W'(CFG_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_PHY  = CNT_W'(PHY_EN_CYC - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        retry_q, retry_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              cam_pwdn_q, cam_pwdn_d;
    logic              cam_rst_n_q, cam_rst_n_d;
    logic              cfg_rst_n_q, cfg_rst_n_d;
    logic              phy_rst_n_q, phy_rst_n_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;
    logic              done_sync;

    // Done is only listened to in CFG; the synchronizer is flushed elsewhere
    // so a done left high from earlier still pays the full sync latency.
    cdc_sync2 u_done_sync (
        .clk   (I_Top_Sys_Clk),
        .rst_n (I_Top_Rst_n),
        .clr   (state_q != ST_CFG),
        .d     (I_Cfg_Done),
        .q     (done_sync)
    );

    // Next-state, shared counter and retry count.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        case (state_q)
            ST_IDLE, ST_READY, ST_FAULT: begin
                if (I_Start) begin
                    state_d = ST_PWR_DN;
                    cnt_d   = LD_PWDN;
                    retry_d = '0;
                end
            end
            ST_PWR_DN: begin
                if (cnt_q == '0) begin
                    state_d = ST_RST_HOLD;
                    cnt_d   = LD_RST;
                end
            end
            ST_RST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_BOOT_WAIT;
                    cnt_d   = LD_BOOT;
                end
            end
            ST_BOOT_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_CFG;
                    cnt_d   = LD_CFG;
                end
            end
            ST_CFG: begin
                // Done takes priority over a coincident timeout.
                if (done_sync) begin
                    state_d = ST_PHY_EN;
                    cnt_d   = LD_PHY;
                end else if (cnt_q == '0) begin
                    if (RETRY_EN && (32'(retry_q) + 32'd1 < MAX_RETRY)) begin
                        state_d = ST_PWR_DN;
                        cnt_d   = LD_PWDN;
                        retry_d = retry_q + 2'd1;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_PHY_EN: begin
                if (cnt_q == '0) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so outputs register alongside state.
    always_comb begin
        cam_pwdn_d  = 1'b1;
        cam_rst_n_d = 1'b0;
        cfg_rst_n_d = 1'b0;
        phy_rst_n_d = 1'b0;
        ready_d     = 1'b0;
        fault_d     = 1'b0;
        div_d       = div_q + DIV_W'(1);
        case (state_d)
            ST_RST_HOLD: begin
                cam_pwdn_d = 1'b0;
            end
            ST_BOOT_WAIT: begin
                cam_pwdn_d  = 1'b0;
                cam_rst_n_d = 1'b1;
            end
            ST_CFG: begin
                cam_pwdn_d  = 1'b0;
                cam_rst_n_d = 1'b1;
                cfg_rst_n_d = 1'b1;
            end
            ST_PHY_EN: begin
                cam_pwdn_d  = 1'b0;
                cam_rst_n_d = 1'b1;
                cfg_rst_n_d = 1'b1;
                phy_rst_n_d = 1'b1;
            end
            ST_READY: begin
                cam_pwdn_d  = 1'b0;
                cam_rst_n_d = 1'b1;
                cfg_rst_n_d = 1'b1;
                phy_rst_n_d = 1'b1;
                ready_d     = 1'b1;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counter, divider and registered outputs.
    always_ff @(posedge I_Top_Sys_Clk or negedge I_Top_Rst_n) begin
        if (!I_Top_Rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            div_q       <= '0;
            cam_pwdn_q  <= 1'b1;
            cam_rst_n_q <= 1'b0;
            cfg_rst_n_q <= 1'b0;
            phy_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            div_q       <= div_d;
            cam_pwdn_q  <= cam_pwdn_d;
            cam_rst_n_q <= cam_rst_n_d;
            cfg_rst_n_q <= cfg_rst_n_d;
            phy_rst_n_q <= phy_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign O_Cfg_Sclk  = div_q[DIV_W-1];
    assign O_Cam_Pwdn  = cam_pwdn_q;
    assign O_Cam_Rst_n = cam_rst_n_q;
    assign O_Cfg_Rst_n = cfg_rst_n_q;
    assign O_Phy_Rst_n = phy_rst_n_q;
    assign O_Ready     = ready_q;
    assign O_Fault     = fault_q;
    assign O_State     = state_q;
    assign O_Retry_Cnt = retry_q;

endmodule

// File: tb/tb_mipi_cam_init_seq.sv
// Directed bench for mipi_cam_init_seq with shortened timing parameters.
// Timeout expectations follow MIPI_SEQ_RETRY_EN as built.
module tb_mipi_cam_init_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       done;
    logic       sclk;
    logic       pwdn;
    logic       cam_rst_n;
    logic       cfg_rst_n;
    logic       phy_rst_n;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [1:0] retry;

    int total = 0;
    int bad   = 0;

    mipi_cam_init_seq #(
        .PWDN_CYC        (4),
        .RST_CYC         (8),
        .BOOT_CYC        (6),
        .CFG_TIMEOUT_CYC (20),
        .MAX_RETRY       (2)
    ) dut (
        .I_Top_Sys_Clk (clk),
        .I_Top_Rst_n   (rst_n),
        .I_Start       (start),
        .I_Cfg_Done    (done),
        .O_Cfg_Sclk    (sclk),
        .O_Cam_Pwdn    (pwdn),
        .O_Cam_Rst_n   (cam_rst_n),
        .O_Cfg_Rst_n   (cfg_rst_n),
        .O_Phy_Rst_n   (phy_rst_n),
        .O_Ready       (ready),
        .O_Fault       (fault),
        .O_State       (state),
        .O_Retry_Cnt   (retry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks, landing 1 time unit after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        start = 1'b0;
        done  = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick(2);

        // Reset values
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pwdn", 32'(pwdn), 32'd1);
        chk("rst_cam_rst", 32'(cam_rst_n), 32'd0);
        chk("rst_cfg_rst", 32'(cfg_rst_n), 32'd0);
        chk("rst_phy_rst", 32'(phy_rst_n), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_retry", 32'(retry), 32'd0);
        chk("rst_sclk", 32'(sclk), 32'd0);

        // Release; no auto start, divider MSB toggles after 32 clocks
        rst_n = 1'b1;
        tick(31);
        chk("sclk_31", 32'(sclk), 32'd0);
        chk("idle_hold", 32'(state), 32'd0);
        tick(1);
        chk("sclk_32", 32'(sclk), 32'd1);

        // Nominal sequence
        pulse_start();
        chk("pwr_dn_entry", 32'(state), 32'd1);
        chk("pwr_dn_pwdn", 32'(pwdn), 32'd1);
        chk("pwr_dn_retry", 32'(retry), 32'd0);
        tick(3);
        chk("pwr_dn_last", 32'(state), 32'd1);
        chk("pwr_dn_last_pwdn", 32'(pwdn), 32'd1);
        tick(1);
        chk("rst_hold_entry", 32'(state), 32'd2);
        chk("rst_hold_pwdn", 32'(pwdn), 32'd0);
        chk("rst_hold_cam", 32'(cam_rst_n), 32'd0);
        tick(7);
        chk("rst_hold_last", 32'(cam_rst_n), 32'd0);
        tick(1);
        chk("boot_entry", 32'(state), 32'd3);
        chk("boot_cam", 32'(cam_rst_n), 32'd1);
        chk("boot_cfg", 32'(cfg_rst_n), 32'd0);
        pulse_start();
        chk("boot_start_ign", 32'(state), 32'd3);
        tick(4);
        chk("boot_last", 32'(state), 32'd3);
        tick(1);
        chk("cfg_entry", 32'(state), 32'd4);
        chk("cfg_cfg_rst", 32'(cfg_rst_n), 32'd1);
        chk("cfg_phy_rst", 32'(phy_rst_n), 32'd0);
        tick(9);
        done = 1'b1;
        tick(2);
        chk("cfg_sync_wait", 32'(state), 32'd4);
        tick(1);
        chk("phy_entry", 32'(state), 32'd5);
        chk("phy_rst", 32'(phy_rst_n), 32'd1);
        tick(15);
        chk("phy_last", 32'(ready), 32'd0);
        tick(1);
        chk("ready_state", 32'(state), 32'd6);
        chk("ready_out", 32'(ready), 32'd1);
        chk("ready_cfg", 32'(cfg_rst_n), 32'd1);
        chk("ready_phy", 32'(phy_rst_n), 32'd1);
        done = 1'b0;
        tick(4);
        chk("ready_done_fall", 32'(ready), 32'd1);

        // Restart from READY, with done held high throughout
        done = 1'b1;
        pulse_start();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_ready", 32'(ready), 32'd0);
        chk("restart_pwdn", 32'(pwdn), 32'd1);
        tick(18);
        chk("held_cfg_entry", 32'(state), 32'd4);
        tick(2);
        chk("held_cfg_3rd", 32'(state), 32'd4);
        tick(1);
        chk("held_cfg_exit", 32'(state), 32'd5);
        tick(16);
        chk("held_ready", 32'(state), 32'd6);
        done = 1'b0;

        // Asynchronous reset in RST_HOLD
        pulse_start();
        tick(4);
        chk("pre_abort", 32'(state), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_pwdn", 32'(pwdn), 32'd1);
        chk("abort_cam", 32'(cam_rst_n), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_sclk", 32'(sclk), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("abort_stay_idle", 32'(state), 32'd0);

        // Configuration timeout
        pulse_start();
        tick(18);
        chk("to_cfg_entry", 32'(state), 32'd4);
        tick(19);
        chk("to_cfg_last", 32'(state), 32'd4);
        tick(1);
`ifdef MIPI_SEQ_RETRY_EN
        chk("to1_state", 32'(state), 32'd1);
        chk("to1_retry", 32'(retry), 32'd1);
        tick(37);
        chk("to2_cfg_last", 32'(state), 32'd4);
        tick(1);
        chk("to2_state", 32'(state), 32'd7);
        chk("to2_retry", 32'(retry), 32'd1);
`else
        chk("to1_state", 32'(state), 32'd7);
        chk("to1_retry", 32'(retry), 32'd0);
`endif
        chk("fault_out", 32'(fault), 32'd1);
        chk("fault_pwdn", 32'(pwdn), 32'd1);
        chk("fault_cam", 32'(cam_rst_n), 32'd0);
        chk("fault_cfg", 32'(cfg_rst_n), 32'd0);

        // Restart from FAULT
        pulse_start();
        chk("fault_restart", 32'(state), 32'd1);
        chk("fault_restart_retry", 32'(retry), 32'd0);
        chk("fault_restart_flt", 32'(fault), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
